sm83_alu_seq: RTL
=================

# sm83_alu_seq

Micro-sequencer that drives the control side of the SM83 nibble-serial ALU. It accepts one 8-bit ALU operation per request and issues the load, enable and carry-control strobes needed to run it through the 4-bit core as two nibble passes. It then collects the result and the Z/N/H/C flags and returns them with a one-cycle done pulse. It sits between the CPU decoder and the ALU datapath.

## Interface
- `ALU_WIDTH`, default 4: ALU core width. Word width is 2×ALU_WIDTH.
- `clk` in 1: clock. All state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_op` in 4: operation code.
  - 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
  - 8 DAA (only with the macro).
- `req_a`, `req_b` in 8: operands A and B.
- `flags_in` in 4: current flags {Z,N,H,C}.
- `done` out 1: one-cycle pulse; `result` and `flags_out` are valid while it is high.
- `result` out 8: operation result.
- `flags_out` out 4: new flags {Z,N,H,C}.
- ALU control outputs, 1 bit each:
  - `load_a`, `load_b`, `shift_oe`, `result_oe`, `op_low`, `op_b_high`.
  - `negate`, `carry_in`, `no_carry_out`, `force_carry`, `ignore_carry`.
- `alu_din` out 8: ALU bus input.
- ALU status inputs:
  - `alu_dout` in 8: ALU bus output.
  - `alu_carry`, `alu_zero` in 1 each.
  - `daa_l_gt_9`, `daa_h_gt_9`, `daa_h_eq_9` in 1 each.
- Outside this block, the ALU's `shift_l`, `shift_r`, `load_a_low`, `load_a_zero`, `load_b_lq`, `load_b_zero`, `op_a_oe`, `op_b_oe` and `bs_oe` are tied low.

## Operation
- **States:** IDLE, LDA, LDB, LO, HI, DONE.
- **Accept and sequence:**
  - `req_ready` = IDLE or DONE. A request is accepted on a posedge with `req_valid & req_ready`.
  - On acceptance, op, A, B and flags are latched and the state goes to LDA.
  - The states then advance unconditionally: LDA→LDB→LO→HI→DONE.
  - From DONE: go to LDA on a new accept, else to IDLE.
- **Strobe decode:** ALU strobes decode combinationally from the state and latched op only, so they are stable before the ALU's negedge loads.
- **LDA:** `alu_din`=A, `shift_oe`=1, `load_a`=1.
- **LDB:** `alu_din`=B, `shift_oe`=1, `load_b`=1. For DAA, B is the correction byte registered at the end of LDA.
- **LO:** `op_low`=1, `op_b_high`=0. At the posedge, capture `lc`=`alu_carry`.
- **HI:** `op_low`=0, `op_b_high`=1, `result_oe`=1. At the posedge, capture `hc`=`alu_carry`, `r`=`alu_dout`, `z`=`alu_zero`.
- **Core settings per op** (R=`no_carry_out`, S=`force_carry`, V=`ignore_carry`). `carry_in` applies in LO; in HI, arithmetic ops use `lc`:
  - ADD: R=S=V=0, carry_in=0.
  - ADC: as ADD with carry_in=C.
  - SUB/CP: `negate`=1, carry_in=1.
  - SBC: `negate`=1, carry_in=!C.
  - AND: S=1, carry_in=1, in both passes.
  - XOR: R=1, carry_in=0.
  - OR: R=S=V=1, carry_in=0.
- **Flags:**
  - ADD/ADC: Z=z, N=0, H=lc, C=hc.
  - SUB/SBC/CP: N=1, H=!lc, C=!hc.
  - AND: H=1, C=0, N=0.
  - XOR/OR: N=H=C=0.
- **Result:** `r` for all ops except CP, which returns A with Z from the subtraction.
- **Unused opcodes** (9–15, and 8 without the macro): run the full sequence but return `result`=A and `flags_out`=`flags_in`.
- **Reset:** valid in any state, including mid-op.
  - State goes to IDLE; `done`=0, `result`=0, `flags_out`=0.
  - All ALU strobes 0, `alu_din`=0, `req_ready`=1 after the edge.

## Timing
- Accept at edge E0. LDA runs during E0–E1, LDB E1–E2, LO E2–E3, HI E3–E4.
- `done`=1 for exactly one cycle after E4. Latency is 4 edges.
- Back-to-back: `req_valid` held in DONE is accepted at E5, giving one op per 5 cycles.
- `result` and `flags_out` hold their values until the next HI capture.

## Configuration
- `SM83_ALU_SEQ_DAA_EN` defined: op 8 = DAA on A, using `flags_in`.
  - **Correction, registered at the end of LDA:**
    - `hi_adj` = (N ? C : C | daa_h_gt_9 | (daa_h_eq_9 & daa_l_gt_9)).
    - `lo_adj` = (N ? H : H | daa_l_gt_9).
    - Correction byte = {hi_adj?6:0, lo_adj?6:0}.
  - **Core:** N=0 runs as ADD; N=1 runs as SUB.
  - **Flags:** Z=z, N unchanged, H=0, C = C_in | (!N & hi_adj).
- Undefined: op 8 behaves as an unused opcode. No DAA logic is synthesized and the `daa_*` inputs are ignored.

## Test plan
- ADD A=0x3A B=0xC6 → `result` 0x00, flags Z1 N0 H1 C1; `done` pulses exactly 4 edges after accept.
- SBC A=0x3B B=0x2A C=1 → 0x10, Z0 N1 H0 C0. SUB A=0x3E B=0x0F → 0x2F, N1 H1 C0.
- AND 0x5A,0x3F → 0x1A (H1 C0); XOR 0xFF,0xFF → 0x00 (Z1); OR 0x00,0x00 → 0x00 (Z1 H0 C0).
- CP A=0x3C B=0x40 → `result` 0x3C, Z0 N1 H0 C1. A second request held valid during DONE is accepted with no IDLE cycle.
- Assert `reset` in LO → next cycle IDLE, all strobes 0, `done` never pulses, `req_ready`=1.
- With DAA_EN: DAA, A=0x3C, flags N0 H0 C0 → 0x42, C0. Without it: op 8, A=0x3C, `flags_in`=0xF → `result` 0x3C, `flags_out` 0xF.

Source files
------------

// File: rtl/sm83_alu_seq.sv
// Control sequencer for the SM83 nibble-serial ALU: runs one 8-bit op as LDA/LDB/LO/HI passes.
// Optional DAA support (op 8) is built when SM83_ALU_SEQ_DAA_EN is defined.
module sm83_alu_seq #(
  parameter int ALU_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [2*ALU_WIDTH-1:0] req_a,
  input  logic [2*ALU_WIDTH-1:0] req_b,
  input  logic [3:0]             flags_in,
  output logic                   done,
  output logic [2*ALU_WIDTH-1:0] result,
  output logic [3:0]             flags_out,
  output logic                   load_a,
  output logic                   load_b,
  output logic                   shift_oe,
  output logic                   result_oe,
  output logic                   op_low,
  output logic                   op_b_high,
  output logic                   negate,
  output logic                   carry_in,
  output logic                   no_carry_out,
  output logic                   force_carry,
  output logic                   ignore_carry,
  output logic [2*ALU_WIDTH-1:0] alu_din,
  input  logic [2*ALU_WIDTH-1:0] alu_dout,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   daa_l_gt_9,
  input  logic                   daa_h_gt_9,
  input  logic                   daa_h_eq_9
);

  localparam int W = 2 * ALU_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LDA  = 3'd1;
  localparam logic [2:0] S_LDB  = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_HI   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
  localparam logic [3:0] OP_DAA = 4'd8;

  logic [2:0]   r_state;
  logic [3:0]   r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [3:0]   r_flags;
  logic         r_lc;
  logic [W-1:0] r_result;
  logic [3:0]   r_flags_out;

  logic         w_accept;
  logic         w_arith;
  logic         w_neg;
  logic         w_r;
  logic         w_s;
  logic         w_v;
  logic         w_cin_lo;
  logic [W-1:0] w_result_new;
  logic [3:0]   w_flags_new;

  assign req_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept  = req_valid & req_ready;
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign flags_out = r_flags_out;

`ifdef SM83_ALU_SEQ_DAA_EN
  logic                 r_hi_adj;
  logic                 w_hi_adj;
  logic                 w_lo_adj;
  logic [ALU_WIDTH-1:0] w_corr_hi;
  logic [ALU_WIDTH-1:0] w_corr_lo;

  // Subtract-mode DAA only undoes adjustments flagged by H/C; add-mode also checks digit range.
  assign w_hi_adj  = r_flags[2] ? r_flags[0]
                                : (r_flags[0] | daa_h_gt_9 | (daa_h_eq_9 & daa_l_gt_9));
  assign w_lo_adj  = r_flags[2] ? r_flags[1] : (r_flags[1] | daa_l_gt_9);
  assign w_corr_hi = w_hi_adj ? ALU_WIDTH'(6) : {ALU_WIDTH{1'b0}};
  assign w_corr_lo = w_lo_adj ? ALU_WIDTH'(6) : {ALU_WIDTH{1'b0}};
`else
  logic w_unused_daa;
  assign w_unused_daa = daa_l_gt_9 ^ daa_h_gt_9 ^ daa_h_eq_9;
`endif

  always_comb begin
    w_arith  = 1'b1;
    w_neg    = 1'b0;
    w_r      = 1'b0;
    w_s      = 1'b0;
    w_v      = 1'b0;
    w_cin_lo = 1'b0;
    case (r_op)
      OP_ADC:        w_cin_lo = r_flags[0];
      OP_SUB, OP_CP: begin w_neg = 1'b1; w_cin_lo = 1'b1; end
      OP_SBC:        begin w_neg = 1'b1; w_cin_lo = ~r_flags[0]; end
      OP_AND:        begin w_arith = 1'b0; w_s = 1'b1; w_cin_lo = 1'b1; end
      OP_XOR:        begin w_arith = 1'b0; w_r = 1'b1; end
      OP_OR:         begin w_arith = 1'b0; w_r = 1'b1; w_s = 1'b1; w_v = 1'b1; end
`ifdef SM83_ALU_SEQ_DAA_EN
      OP_DAA:        begin w_neg = r_flags[2]; w_cin_lo = r_flags[2]; end
`endif
      default:       ;
    endcase
  end

  // Strobes depend only on state and latched op so they settle well before the ALU's negedge loads.
  always_comb begin
    load_a       = 1'b0;
    load_b       = 1'b0;
    shift_oe     = 1'b0;
    result_oe    = 1'b0;
    op_low       = 1'b0;
    op_b_high    = 1'b0;
    negate       = 1'b0;
    carry_in     = 1'b0;
    no_carry_out = 1'b0;
    force_carry  = 1'b0;
    ignore_carry = 1'b0;
    alu_din      = '0;
    case (r_state)
      S_LDA: begin
        alu_din  = r_a;
        shift_oe = 1'b1;
        load_a   = 1'b1;
      end
      S_LDB: begin
        alu_din  = r_b;
        shift_oe = 1'b1;
        load_b   = 1'b1;
      end
      S_LO: begin
        op_low       = 1'b1;
        negate       = w_neg;
        no_carry_out = w_r;
        force_carry  = w_s;
        ignore_carry = w_v;
        carry_in     = w_cin_lo;
      end
      S_HI: begin
        op_b_high    = 1'b1;
        result_oe    = 1'b1;
        negate       = w_neg;
        no_carry_out = w_r;
        force_carry  = w_s;
        ignore_carry = w_v;
        carry_in     = w_arith ? r_lc : w_cin_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_result_new = alu_dout;
    w_flags_new  = r_flags;
    case (r_op)
      OP_ADD, OP_ADC: w_flags_new = {alu_zero, 1'b0, r_lc, alu_carry};
      OP_SUB, OP_SBC: w_flags_new = {alu_zero, 1'b1, ~r_lc, ~alu_carry};
      OP_CP: begin
        w_flags_new  = {alu_zero, 1'b1, ~r_lc, ~alu_carry};
        w_result_new = r_a;
      end
      OP_AND:         w_flags_new = {alu_zero, 3'b010};
      OP_XOR, OP_OR:  w_flags_new = {alu_zero, 3'b000};
`ifdef SM83_ALU_SEQ_DAA_EN
      OP_DAA:         w_flags_new = {alu_zero, r_flags[2], 1'b0,
                                     r_flags[0] | (~r_flags[2] & r_hi_adj)};
`endif
      default:        w_result_new = r_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_flags_out <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= S_LDA;
        S_LDA:   r_state <= S_LDB;
        S_LDB:   r_state <= S_LO;
        S_LO:    r_state <= S_HI;
        S_HI: begin
          r_state     <= S_DONE;
          r_result    <= w_result_new;
          r_flags_out <= w_flags_new;
        end
        S_DONE:  r_state <= w_accept ? S_LDA : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand/carry holding registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= req_op;
      r_a     <= req_a;
      r_b     <= req_b;
      r_flags <= flags_in;
    end
`ifdef SM83_ALU_SEQ_DAA_EN
    if (r_state == S_LDA && r_op == OP_DAA) begin
      r_b      <= {w_corr_hi, w_corr_lo};
      r_hi_adj <= w_hi_adj;
    end
`endif
    if (r_state == S_LO) r_lc <= alu_carry;
  end

endmodule
